// File: rtl/pulse_capture_pkg.sv
// pulse_capture_pkg: shared record type, capture FSM states and default parameters
// for the multi-receiver pulse capture block.
package pulse_capture_pkg;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_RECEIVERS_DEF      = 4;
    localparam int TS_WIDTH_DEF         = 24;
    localparam int PW_WIDTH_DEF         = 16;
    localparam int MIN_PULSE_CYCLES_DEF = 48;
    localparam int FIFO_DEPTH_DEF       = 16;
    localparam bit ENV_ACTIVE_LOW_DEF   = 1'b1;
    localparam int CH_W_DEF             = ch_width(N_RECEIVERS_DEF);

    typedef enum logic {IDLE, ACTIVE} cap_state_e;

    typedef struct packed {
        logic [CH_W_DEF-1:0]     channel;
        logic [TS_WIDTH_DEF-1:0] timestamp;
        logic [PW_WIDTH_DEF-1:0] width;
        logic                    timeout;
    } pulse_rec_t;

endpackage

// File: rtl/pulse_capture_channel.sv
// pulse_capture_channel: one receiver lane -- envelope synchroniser, edge detect,
// capture FSM and a single-entry holding register.
//  clk_96MHz, reset_n   clock, asynchronous active-low reset
//  e_in                 raw envelope pin (asynchronous)
//  configured           lane enable; dropping it mid-pulse aborts the pulse
//  system_timestamp     free-running time base
//  clear_overflow       clears overflow_sticky (a simultaneous drop wins)
//  grant                arbiter takes the held record this cycle
//  hold_valid/hold_rec  held record presented to the arbiter
//  overflow_sticky      a record was dropped since the last clear
module pulse_capture_channel
    import pulse_capture_pkg::*;
#(
    parameter int TS_WIDTH         = TS_WIDTH_DEF,
    parameter int PW_WIDTH         = PW_WIDTH_DEF,
    parameter int MIN_PULSE_CYCLES = MIN_PULSE_CYCLES_DEF,
    parameter bit ENV_ACTIVE_LOW   = ENV_ACTIVE_LOW_DEF,
    parameter int CH_IDX           = 0
) (
    input  logic                clk_96MHz,
    input  logic                reset_n,
    input  logic                e_in,
    input  logic                configured,
    input  logic [TS_WIDTH-1:0] system_timestamp,
    input  logic                clear_overflow,
    input  logic                grant,
    output logic                hold_valid,
    output pulse_rec_t          hold_rec,
    output logic                overflow_sticky
);
    localparam logic ENV_IDLE = ENV_ACTIVE_LOW;

    logic sync1_q, sync1_d, sync2_q, sync2_d, env_q, env_d;
    logic [2:0] live_q, live_d;
    logic rise_q, rise_d, fall_q, fall_d;
    cap_state_e state_q, state_d;
    logic [TS_WIDTH-1:0] start_q, start_d;
    logic [PW_WIDTH-1:0] width_q, width_d;
    logic hold_valid_q, hold_valid_d, ovf_q, ovf_d, done;
    pulse_rec_t hold_q, hold_d;

    always_comb begin
        sync1_d = e_in;
        sync2_d = sync1_q;
        env_d = sync2_q;
        // Edges count only once the pipeline holds real pin samples, so a pin
        // already active when reset releases is not mistaken for a new pulse.
        live_d = {live_q[1:0], 1'b1};
        rise_d = live_q[2] && (sync2_q != ENV_IDLE) && (env_q == ENV_IDLE);
        fall_d = live_q[2] && (sync2_q == ENV_IDLE) && (env_q != ENV_IDLE);
        state_d = state_q;
        start_d = start_q;
        width_d = width_q;
        done = 1'b0;
        hold_valid_d = hold_valid_q && !grant;
        hold_d = hold_q;
        ovf_d = ovf_q && !clear_overflow;
        if (state_q == IDLE) begin
            if (rise_q && configured) begin
                state_d = ACTIVE;
                start_d = system_timestamp;
                width_d = PW_WIDTH'(1);
            end
        end else if (!configured) begin
            state_d = IDLE;
        end else if (fall_q) begin
            state_d = IDLE;
            done = 32'(width_q) >= MIN_PULSE_CYCLES;
        end else if (!(&width_q)) begin
            width_d = width_q + PW_WIDTH'(1);
        end
        if (done) begin
            if (hold_valid_q && !grant) begin
                ovf_d = 1'b1;
            end else begin
                hold_valid_d = 1'b1;
                hold_d = '{channel: CH_W_DEF'(CH_IDX), timestamp: start_q, width: width_q, timeout: &width_q};
            end
        end
    end

    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= ENV_IDLE;
            sync2_q      <= ENV_IDLE;
            env_q        <= ENV_IDLE;
            live_q       <= '0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            state_q      <= IDLE;
            start_q      <= '0;
            width_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            env_q        <= env_d;
            live_q       <= live_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            state_q      <= state_d;
            start_q      <= start_d;
            width_q      <= width_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            ovf_q        <= ovf_d;
        end
    end

    assign hold_valid = hold_valid_q;
    assign hold_rec = hold_q;
    assign overflow_sticky = ovf_q;

endmodule

// File: rtl/multi_receiver_pulse_capture.sv
// multi_receiver_pulse_capture: timestamps envelope pulses from N receivers and
// queues the records through a round-robin arbiter into a show-ahead FIFO.
//  clk_96MHz, reset_n      clock, asynchronous active-low reset
//  e_in, configured        per-channel envelope pins and enables
//  system_timestamp        free-running time base
//  clear_overflow          clears overflow_sticky
//  out_ready/out_valid     output handshake; head pops on valid && ready
//  out_channel/_timestamp/_width/_timeout  head record fields
//  fifo_level              FIFO occupancy
//  overflow_sticky         per-channel dropped-record flags
module multi_receiver_pulse_capture
    import pulse_capture_pkg::*;
#(
    parameter int N_RECEIVERS      = N_RECEIVERS_DEF,
    parameter int TS_WIDTH         = TS_WIDTH_DEF,
    parameter int PW_WIDTH         = PW_WIDTH_DEF,
    parameter int MIN_PULSE_CYCLES = MIN_PULSE_CYCLES_DEF,
    parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF,
    parameter bit ENV_ACTIVE_LOW   = ENV_ACTIVE_LOW_DEF,
    localparam int CH_W            = ch_width(N_RECEIVERS),
    localparam int AW              = $clog2(FIFO_DEPTH),
    localparam int LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk_96MHz,
    input  logic                   reset_n,
    input  logic [N_RECEIVERS-1:0] e_in,
    input  logic [N_RECEIVERS-1:0] configured,
    input  logic [TS_WIDTH-1:0]    system_timestamp,
    input  logic                   clear_overflow,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [CH_W-1:0]        out_channel,
    output logic [TS_WIDTH-1:0]    out_timestamp,
    output logic [PW_WIDTH-1:0]    out_width,
    output logic                   out_timeout,
    output logic [LVL_W-1:0]       fifo_level,
    output logic [N_RECEIVERS-1:0] overflow_sticky
);
    logic [N_RECEIVERS-1:0] hold_valid, grant;
    pulse_rec_t hold_rec [N_RECEIVERS];
    logic [CH_W-1:0] last_q, last_d, grant_idx;
    logic grant_any, room, pop, push;
    logic stage_valid_q, stage_valid_d;
    pulse_rec_t stage_q, stage_d, head;
    pulse_rec_t mem_q [FIFO_DEPTH];
    pulse_rec_t mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0] level_q, level_d;

    for (genvar i = 0; i < N_RECEIVERS; i++) begin : g_ch
        pulse_capture_channel #(
            .TS_WIDTH(TS_WIDTH), .PW_WIDTH(PW_WIDTH), .MIN_PULSE_CYCLES(MIN_PULSE_CYCLES),
            .ENV_ACTIVE_LOW(ENV_ACTIVE_LOW), .CH_IDX(i)
        ) u_ch (
            .clk_96MHz(clk_96MHz), .reset_n(reset_n), .e_in(e_in[i]), .configured(configured[i]),
            .system_timestamp(system_timestamp), .clear_overflow(clear_overflow), .grant(grant[i]),
            .hold_valid(hold_valid[i]), .hold_rec(hold_rec[i]), .overflow_sticky(overflow_sticky[i])
        );
    end

    always_comb begin
        pop = out_valid && out_ready;
        push = stage_valid_q;
        // A grant reserves a FIFO slot one cycle ahead, so the staged record
        // must be counted as already occupying the FIFO.
        room = (32'(level_q) + 32'(stage_valid_q) - 32'(pop)) < FIFO_DEPTH;
        grant = '0;
        grant_any = 1'b0;
        grant_idx = last_q;
        for (int o = 1; o <= N_RECEIVERS; o++) begin
            if (room && !grant_any && hold_valid[CH_W'((int'(last_q) + o) % N_RECEIVERS)]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'((int'(last_q) + o) % N_RECEIVERS);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
        last_d = grant_any ? grant_idx : last_q;
        stage_valid_d = grant_any;
        stage_d = grant_any ? hold_rec[grant_idx] : stage_q;
        mem_d = mem_q;
        if (push) mem_d[wr_q] = stage_q;
        wr_d = wr_q + AW'(push);
        rd_d = rd_q + AW'(pop);
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            last_q        <= '0;
            stage_valid_q <= 1'b0;
            stage_q       <= '0;
            mem_q         <= '{default: '0};
            wr_q          <= '0;
            rd_q          <= '0;
            level_q       <= '0;
        end else begin
            last_q        <= last_d;
            stage_valid_q <= stage_valid_d;
            stage_q       <= stage_d;
            mem_q         <= mem_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            level_q       <= level_d;
        end
    end

    assign head = mem_q[rd_q];
    assign out_valid = level_q != '0;
    assign out_channel = head.channel;
    assign out_timestamp = head.timestamp;
    assign out_width = head.width;
    assign out_timeout = head.timeout;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_multi_receiver_pulse_capture.sv
// tb_multi_receiver_pulse_capture: directed pulses with a scoreboard queue and an output monitor.
module tb_multi_receiver_pulse_capture;
    typedef struct {
        int         ch;
        logic [23:0] ts;
        logic [15:0] w;
        logic        to;
    } exp_t;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [3:0] e_in = 4'hF, configured = 4'h0;
    logic clear_overflow = 1'b0, out_ready = 1'b0;
    logic [23:0] ts_off = '0, system_timestamp;
    int unsigned cyc = 0;
    logic out_valid, out_timeout;
    logic [1:0] out_channel;
    logic [23:0] out_timestamp;
    logic [15:0] out_width;
    logic [4:0] fifo_level;
    logic [3:0] overflow_sticky;
    exp_t q[$];
    int n_tests = 0, n_fail = 0;

    multi_receiver_pulse_capture dut (
        .clk_96MHz(clk), .reset_n(reset_n), .e_in(e_in), .configured(configured),
        .system_timestamp(system_timestamp), .clear_overflow(clear_overflow), .out_ready(out_ready),
        .out_valid(out_valid), .out_channel(out_channel), .out_timestamp(out_timestamp),
        .out_width(out_width), .out_timeout(out_timeout), .fifo_level(fifo_level),
        .overflow_sticky(overflow_sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign system_timestamp = ts_off + cyc[23:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_record: got ch=%0d ts=0x%0h w=%0d expected none",
                         out_channel, out_timestamp, out_width);
            end else begin
                check("rec_channel", 32'(out_channel), 32'(q[0].ch));
                check("rec_timestamp", 32'(out_timestamp), 32'(q[0].ts));
                check("rec_width", 32'(out_width), 32'(q[0].w));
                check("rec_timeout", 32'(out_timeout), 32'(q[0].to));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_level"}, 32'(fifo_level), 0);
        check({tag, "_channel"}, 32'(out_channel), 0);
        check({tag, "_timestamp"}, 32'(out_timestamp), 0);
        check({tag, "_width"}, 32'(out_width), 0);
        check({tag, "_timeout"}, 32'(out_timeout), 0);
        check({tag, "_overflow"}, 32'(overflow_sticky), 0);
    endtask

    initial begin
        logic [23:0] t;
        int unsigned c0;
        step(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        configured = 4'hF;
        step(5);

        // a queued record and a pulse in flight, then reset mid-pulse
        t = system_timestamp + 24'd3;
        e_in[3] = 1'b0;
        step(50);
        e_in[3] = 1'b1;
        q.push_back(exp_t'{3, t, 16'd50, 1'b0});
        step(10);
        check("pre_reset_level", 32'(fifo_level), 1);
        e_in[0] = 1'b0;
        step(20);
        reset_n = 1'b0;
        q.delete();
        step(2);
        check_all_zero("mid_pulse_reset");
        reset_n = 1'b1;
        step(100);
        e_in[0] = 1'b1;
        step(20);
        check("held_across_reset_level", 32'(fifo_level), 0);

        // single 200-cycle pulse on ch2 starting at ts 0x100
        out_ready = 1'b1;
        ts_off = 24'h000100 - cyc[23:0];
        e_in[2] = 1'b0;
        step(200);
        e_in[2] = 1'b1;
        c0 = cyc;
        q.push_back(exp_t'{2, 24'h000103, 16'd200, 1'b0});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("latency", cyc - c0, 6);
        step(10);

        // 20-cycle glitch is rejected
        e_in[1] = 1'b0;
        step(20);
        e_in[1] = 1'b1;
        step(20);
        check("glitch_level", 32'(fifo_level), 0);
        check("glitch_valid", 32'(out_valid), 0);

        // long pulse saturates the width counter
        t = system_timestamp + 24'd3;
        e_in[0] = 1'b0;
        step(66000);
        e_in[0] = 1'b1;
        q.push_back(exp_t'{0, t, 16'hFFFF, 1'b1});
        step(15);

        // four pulses ending together; last grant was ch0 so order is 1,2,3,0
        out_ready = 1'b0;
        begin
            logic [23:0] ts4 [4];
            for (int c = 0; c < 4; c++) begin
                ts4[c] = system_timestamp + 24'd3;
                e_in[c] = 1'b0;
                step(10);
            end
            step(50);
            e_in = 4'hF;
            c0 = cyc;
            q.push_back(exp_t'{1, ts4[1], 16'd80, 1'b0});
            q.push_back(exp_t'{2, ts4[2], 16'd70, 1'b0});
            q.push_back(exp_t'{3, ts4[3], 16'd60, 1'b0});
            q.push_back(exp_t'{0, ts4[0], 16'd90, 1'b0});
        end
        step(6);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("rr_consecutive_level", 32'(fifo_level), 32'(i));
        end
        check("rr_no_overflow", 32'(overflow_sticky), 0);
        out_ready = 1'b1;
        step(15);

        // fill FIFO (4 rounds), fill holding registers (round 5), drop (round 6)
        out_ready = 1'b0;
        for (int r = 0; r < 6; r++) begin
            t = system_timestamp + 24'd3;
            e_in = 4'h0;
            step(50);
            e_in = 4'hF;
            if (r < 5) begin
                q.push_back(exp_t'{1, t, 16'd50, 1'b0});
                q.push_back(exp_t'{2, t, 16'd50, 1'b0});
                q.push_back(exp_t'{3, t, 16'd50, 1'b0});
                q.push_back(exp_t'{0, t, 16'd50, 1'b0});
            end else begin
                step(3);
                clear_overflow = 1'b1;
                step(1);
                clear_overflow = 1'b0;
            end
            step(20);
            if (r == 3) check("fifo_full_level", 32'(fifo_level), 16);
        end
        check("overflow_set_wins", 32'(overflow_sticky), 32'hF);
        check("full_level_held", 32'(fifo_level), 16);
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        check("drain_remaining", 32'(q.size()), 0);
        step(5);
        check("drain_level", 32'(fifo_level), 0);
        check("overflow_before_clear", 32'(overflow_sticky), 32'hF);
        clear_overflow = 1'b1;
        step(1);
        clear_overflow = 1'b0;
        step(1);
        check("overflow_cleared", 32'(overflow_sticky), 0);

        // configured[1] dropped mid-pulse
        e_in[1] = 1'b0;
        step(30);
        configured[1] = 1'b0;
        step(70);
        e_in[1] = 1'b1;
        step(20);
        configured[1] = 1'b1;
        step(5);
        check("abort_level", 32'(fifo_level), 0);
        check("abort_valid", 32'(out_valid), 0);

        // timestamp wrap
        ts_off = 24'hFFFFF0 - cyc[23:0];
        e_in[3] = 1'b0;
        step(60);
        e_in[3] = 1'b1;
        q.push_back(exp_t'{3, 24'hFFFFF3, 16'd60, 1'b0});
        step(20);
        check("final_queue_empty", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
